// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO read-side streamer.
// Data width default comes from the shared WIDTH define.
`ifndef WIDTH
`define WIDTH 8
`endif

package fifo_stream_pkg;

  localparam int DEF_WIDTH   = `WIDTH;
  localparam int DEF_PKT_LEN = 4;
  localparam int BUF_DEPTH   = 3;

  typedef logic [1:0]  occ_t;
  typedef logic [15:0] pkt_cnt_t;

  // Circular pointer step over the 3-entry buffer.
  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry circular buffer decoupling FIFO reads
// from the downstream valid/ready handshake.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output occ_t             occ_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [1:0]       wr_q, wr_d;
  logic [1:0]       rd_q, rd_d;
  occ_t             occ_q, occ_d;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push_i) wr_d = ptr_inc(wr_q);
    if (pop_i)  rd_d = ptr_inc(rd_q);
    unique case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Storage; cleared so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o = mem_q[rd_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side drain: credit-gated reads, 1-cycle capture,
// and a packet-framed valid/ready output stream.
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PKT_LEN = DEF_PKT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_enb,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output pkt_cnt_t         pkt_cnt,
  output logic             busy
);

  occ_t       occ;
  logic       inflight_q;
  logic [2:0] credit;
  logic       hs;
  logic       at_last;
  logic [7:0] beat_q, beat_d;
  pkt_cnt_t   pkt_q, pkt_d;

  // Credit counts words buffered plus the read in flight,
  // so a read is only issued when its landing slot is free.
  assign credit      = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_enb = !rst && !fifo_empty
                     && (credit < 3'(BUF_DEPTH));

  assign m_valid = (occ != '0);
  assign hs      = m_valid && m_ready;
  assign at_last = (beat_q == 8'(PKT_LEN - 1));
  assign m_last  = m_valid && at_last;
  assign busy    = m_valid || inflight_q;
  assign pkt_cnt = pkt_q;

  stream_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_rd_data),
    .pop_i       (hs),
    .head_o      (m_data),
    .occ_o       (occ)
  );

  // Beat and packet counter next-state.
  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (hs) begin
      if (at_last) begin
        beat_d = '0;
        pkt_d  = pkt_q + 16'd1;
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end
  end

  // In-flight flag and framing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      pkt_q      <= '0;
    end else begin
      inflight_q <= fifo_rd_enb;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
    end
  end

endmodule
